// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data-memory stage with stall/done handshake
//
// Purpose: word-addressed data memory sitting after the ALU. Aligned loads and
// stores are accepted in IDLE, held for LATENCY wait cycles, committed on the
// last wait edge (or the accept edge when LATENCY=0) and reported in DONE.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   mem_read_i   load request
//   mem_write_i  store request (wins when both requests are high)
//   addr_i       byte address; word index = addr_i[IDX_W+1:2], upper bits ignored
//   wdata_i      store data
//   rdata_o      last completed load result
//   stall_o      CPU must hold PC and register write
//   done_o       access completes this cycle
//   misalign_o   request in IDLE with addr_i[1:0] != 0

module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;

    // Request copies latched at accept; inputs are ignored while busy.
    logic               op_write;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        wdata_lat;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req;
    logic               aligned;
    logic               accept;
    logic [IDX_W-1:0]   addr_idx;

    logic               commit;
    logic               commit_write;
    logic [IDX_W-1:0]   commit_idx;
    logic [31:0]        commit_data;

    // Address bits above the array size wrap and are deliberately dropped.
    logic               unused_addr;
    assign unused_addr = ^addr_i[31:IDX_W+2];

    assign req      = mem_read_i | mem_write_i;
    assign aligned  = (addr_i[1:0] == 2'b00);
    assign addr_idx = addr_i[IDX_W+1:2];

    assign done_o = (state == ST_DONE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        commit_write = op_write;
        commit_idx   = idx;
        commit_data  = wdata_lat;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        accept  = 1'b1;
                        cnt_nxt = LAT4;
                        if (LATENCY == 0) begin
                            // No wait cycles: commit straight from the live inputs.
                            state_nxt    = ST_DONE;
                            commit       = 1'b1;
                            commit_write = mem_write_i;
                            commit_idx   = addr_idx;
                            commit_data  = wdata_i;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_DONE;
                    commit    = 1'b1;
                end
            end
            ST_DONE: begin
                // Request still visible here belongs to the finished access.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            idx       <= '0;
            wdata_lat <= '0;
            rdata_o   <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_write  <= mem_write_i;
                idx       <= addr_idx;
                wdata_lat <= wdata_i;
            end
            if (commit) begin
                if (commit_write) begin
                    mem[commit_idx] <= commit_data;
                end else begin
                    rdata_o <= mem[commit_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (LATENCY 2 and 0)

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  rd_i;
    logic [1:0]  wr_i;
    logic [31:0] ad_i [2];
    logic [31:0] wd_i [2];
    logic [31:0] rdata [2];
    logic [1:0]  stall;
    logic [1:0]  done;
    logic [1:0]  mis;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .mem_read_i(rd_i[0]), .mem_write_i(wr_i[0]),
        .addr_i(ad_i[0]), .wdata_i(wd_i[0]), .rdata_o(rdata[0]),
        .stall_o(stall[0]), .done_o(done[0]), .misalign_o(mis[0])
    );

    data_mem_ctrl #(.DEPTH_WORDS(128), .LATENCY(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .mem_read_i(rd_i[1]), .mem_write_i(wr_i[1]),
        .addr_i(ad_i[1]), .wdata_i(wd_i[1]), .rdata_o(rdata[1]),
        .stall_o(stall[1]), .done_o(done[1]), .misalign_o(mis[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: per DUT, ph = cycles elapsed since the accept cycle of the
    // access in flight (-1 when free). Stall covers ages 0..L, done is age L+1,
    // the memory effect lands at the end of age L.
    int          lat [2] = '{2, 0};
    int          ph [2];
    logic [1:0]  started;
    logic        pw [2];
    logic [6:0]  pidx [2];
    logic [31:0] pdat [2];
    logic [31:0] mrd [2];
    logic [31:0] mem_m [2][128];

    initial begin
        int   eff;
        logic req;
        logic al;
        logic e_st;
        logic e_dn;
        logic e_mis;
        started = 2'b00;
        for (int d = 0; d < 2; d++) begin
            ph[d]  = -1;
            mrd[d] = '0;
            for (int i = 0; i < 128; i++) mem_m[d][i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                req = rd_i[d] | wr_i[d];
                al  = (ad_i[d][1:0] == 2'b00);
                if (ph[d] < 0) begin
                    e_st  = req & al;
                    e_dn  = 1'b0;
                    e_mis = req & ~al;
                end else begin
                    e_st  = (ph[d] <= lat[d]);
                    e_dn  = (ph[d] == lat[d] + 1);
                    e_mis = 1'b0;
                end
                if (started[d]) begin
                    chk($sformatf("model d%0d stall", d), 32'(stall[d]), 32'(e_st));
                    chk($sformatf("model d%0d done", d), 32'(done[d]), 32'(e_dn));
                    chk($sformatf("model d%0d misalign", d), 32'(mis[d]), 32'(e_mis));
                    chk($sformatf("model d%0d rdata", d), rdata[d], mrd[d]);
                end
                if (rst[d]) begin
                    ph[d]  = -1;
                    mrd[d] = '0;
                    for (int i = 0; i < 128; i++) mem_m[d][i] = '0;
                    started[d] = 1'b1;
                end else begin
                    eff = ph[d];
                    if (eff < 0 && req && al) begin
                        eff     = 0;
                        pw[d]   = wr_i[d];
                        pidx[d] = ad_i[d][8:2];
                        pdat[d] = wd_i[d];
                    end
                    if (eff >= 0 && eff == lat[d]) begin
                        if (pw[d]) mem_m[d][pidx[d]] = pdat[d];
                        else       mrd[d] = mem_m[d][pidx[d]];
                    end
                    ph[d] = (eff < 0 || eff == lat[d] + 1) ? -1 : eff + 1;
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; holds the request through DONE,
    // pins the stall/done timeline and returns rdata seen in the done cycle.
    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] dt, output logic [31:0] rd_done);
        int l;
        l       = (d == 0) ? 2 : 0;
        rd_done = '0;
        rd_i[d] = r;
        wr_i[d] = w;
        ad_i[d] = a;
        wd_i[d] = dt;
        for (int c = 0; c <= l + 2; c++) begin
            @(negedge clk);
            chk($sformatf("d%0d a%h stall c%0d", d, a, c), 32'(stall[d]), (c <= l) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d a%h done c%0d", d, a, c), 32'(done[d]), (c == l + 1) ? 32'd1 : 32'd0);
            if (c == l + 1) rd_done = rdata[d];
            @(posedge clk);
            #1;
            if (c == l + 1) begin
                rd_i[d] = 1'b0;
                wr_i[d] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        rst  = 2'b11;
        rd_i = 2'b00;
        wr_i = 2'b00;
        for (int d = 0; d < 2; d++) begin
            ad_i[d] = '0;
            wd_i[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        @(negedge clk);
        chk("reset rdata", rdata[0], 32'h0);
        chk("reset done", 32'(done[0]), 32'h0);
        chk("reset stall", 32'(stall[0]), 32'h0);
        @(posedge clk);
        #1;

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, r);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, r);
        chk("load 0x10", r, 32'hDEADBEEF);
        @(negedge clk);
        chk("rdata hold", rdata[0], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        access(0, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, r);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, r);
        chk("wrap load 0x0", r, 32'hA5A5A5A5);

        wr_i[0] = 1'b1;
        ad_i[0] = 32'h13;
        wd_i[0] = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("misaligned flag", 32'(mis[0]), 32'h1);
            chk("misaligned stall", 32'(stall[0]), 32'h0);
            chk("misaligned done", 32'(done[0]), 32'h0);
            @(posedge clk);
            #1;
        end
        wr_i[0] = 1'b0;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, r);
        chk("load after misaligned", r, 32'hDEADBEEF);

        wr_i[0] = 1'b1;
        ad_i[0] = 32'h20;
        wd_i[0] = 32'h11111111;
        @(negedge clk);
        chk("abort accept stall", 32'(stall[0]), 32'h1);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort wait stall", 32'(stall[0]), 32'h1);
        @(posedge clk);
        #1;
        rst[0]  = 1'b0;
        wr_i[0] = 1'b0;
        @(negedge clk);
        chk("abort idle stall", 32'(stall[0]), 32'h0);
        chk("abort idle done", 32'(done[0]), 32'h0);
        chk("abort rdata", rdata[0], 32'h0);
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, r);
        chk("load after abort", r, 32'h0);

        access(0, 1'b0, 1'b1, 32'h40, 32'h0BADC0DE, r);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, r);
        chk("load 0x40", r, 32'h0BADC0DE);
        access(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, r);
        chk("both-high rdata kept", r, 32'h0BADC0DE);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, r);
        chk("load 0x30", r, 32'hCAFEF00D);

        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, r);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, r);
        chk("lat0 load 0x10", r, 32'hDEADBEEF);
        access(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, r);
        chk("lat0 both-high rdata kept", r, 32'hDEADBEEF);
        access(1, 1'b1, 1'b0, 32'h30, 32'h0, r);
        chk("lat0 load 0x30", r, 32'hCAFEF00D);

        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d]  = ($urandom_range(0, 199) == 0);
                rd_i[d] = ($urandom_range(0, 1) == 0);
                wr_i[d] = ($urandom_range(0, 2) == 0);
                a       = $urandom & 32'hFFFF_FE00;
                a[5:2]  = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
                ad_i[d] = a;
                wd_i[d] = $urandom;
            end
            @(posedge clk);
            #1;
        end
        rst  = 2'b00;
        rd_i = 2'b00;
        wr_i = 2'b00;
        repeat (20) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
